// File: rtl/ahb_apb_pkg.sv
// ahb_apb_pkg: shared state encoding, AHB constants and transfer decode helpers for the AHB-to-APB bridge.
package ahb_apb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_SETUP,
        ST_ACCESS,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_t;

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    function automatic logic is_active(input logic [1:0] htrans);
        return htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ;
    endfunction

    function automatic logic [3:0] apb_strobe(input logic [2:0] size, input logic [1:0] addr, input logic write);
        return !write ? 4'b0000 :
               size == HSIZE_BYTE ? 4'b0001 << addr :
               size == HSIZE_HALF ? 4'b0011 << {addr[1], 1'b0} : 4'b1111;
    endfunction

    function automatic logic is_aligned(input logic [2:0] size, input logic [1:0] addr);
        return size == HSIZE_BYTE || (size == HSIZE_HALF && !addr[0]) || (size == HSIZE_WORD && addr == 2'b00);
    endfunction

endpackage

// File: rtl/ahb_apb_bridge_if.sv
// ahb_apb_bridge_if: AHB-Lite slave side and APB master side signals of the bridge.
interface ahb_apb_bridge_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic [3:0]  PSEL;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic        PENABLE;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PGRANT;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA,
        output PSEL, PADDR, PWRITE, PWDATA, PSTRB, PENABLE,
        input  PREADY, PRDATA, PGRANT
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA,
        input  PSEL, PADDR, PWRITE, PWDATA, PSTRB, PENABLE,
        output PREADY, PRDATA, PGRANT
    );
endinterface

// File: rtl/apb_timeout_counter.sv
// apb_timeout_counter: reloads on entry to SETUP and flags the last allowed SETUP+ACCESS cycle.
module apb_timeout_counter #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic clear,
    output logic expire
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= W'(LIMIT);
        else if (clear) cnt <= '0;
        else if (cnt != '0) cnt <= cnt - W'(1);
    end

    assign expire = cnt == W'(1);
endmodule

// File: rtl/ahb_apb_bridge.sv
// ahb_apb_bridge: converts each AHB-Lite slave transfer into one APB transaction on an interconnect master port.
// Define APB_TIMEOUT_EN to abort APB transfers that wait longer than TIMEOUT_CYCLES with an ERROR response.
module ahb_apb_bridge
    import ahb_apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic PCLK,
    input logic PRST,
    ahb_apb_bridge_if.slave bus
);
    state_t state;
    logic   accept;
    logic   legal;
    logic   expire;

    assign accept = bus.HSEL && bus.HREADY && is_active(bus.HTRANS) && (state == ST_IDLE || state == ST_DONE);
    assign legal  = is_aligned(bus.HSIZE, bus.HADDR[1:0]);

`ifdef APB_TIMEOUT_EN
    logic load;
    logic clear;

    assign load  = (accept && legal && !bus.HWRITE) || state == ST_WDATA;
    assign clear = state != ST_SETUP && state != ST_ACCESS;

    apb_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk(PCLK),
        .rst(PRST),
        .load(load),
        .clear(clear),
        .expire(expire)
    );
`else
    logic unused_limit;

    assign unused_limit = |TIMEOUT_CYCLES;
    assign expire       = 1'b0;
`endif

    always_ff @(posedge PCLK) begin
        if (PRST) begin
            state         <= ST_IDLE;
            bus.HREADYOUT <= 1'b1;
            bus.HRESP     <= 1'b0;
            bus.HRDATA    <= '0;
            bus.PSEL      <= '0;
            bus.PADDR     <= '0;
            bus.PWRITE    <= 1'b0;
            bus.PWDATA    <= '0;
            bus.PSTRB     <= '0;
            bus.PENABLE   <= 1'b0;
        end else if (accept) begin
            bus.HREADYOUT <= 1'b0;
            if (!legal) begin
                bus.HRESP <= 1'b1;
                state     <= ST_ERR1;
            end else begin
                bus.PADDR  <= bus.HADDR;
                bus.PWRITE <= bus.HWRITE;
                bus.PSTRB  <= apb_strobe(bus.HSIZE, bus.HADDR[1:0], bus.HWRITE);
                bus.PSEL   <= bus.HWRITE ? 4'b0000 : 4'b0001 << bus.HADDR[31:30];
                state      <= bus.HWRITE ? ST_WDATA : ST_SETUP;
            end
        end else begin
            case (state)
                ST_WDATA: begin
                    bus.PWDATA <= bus.HWDATA;
                    bus.PSEL   <= 4'b0001 << bus.PADDR[31:30];
                    state      <= ST_SETUP;
                end
                ST_SETUP, ST_ACCESS: begin
                    // A completing PREADY wins over a timeout in the same cycle
                    if (state == ST_ACCESS && bus.PREADY) begin
                        bus.PSEL      <= '0;
                        bus.PENABLE   <= 1'b0;
                        bus.HREADYOUT <= 1'b1;
                        bus.HRDATA    <= bus.PWRITE ? bus.HRDATA : bus.PRDATA;
                        state         <= ST_DONE;
                    end else if (expire) begin
                        bus.PSEL    <= '0;
                        bus.PENABLE <= 1'b0;
                        bus.HRESP   <= 1'b1;
                        state       <= ST_ERR1;
                    end else if (state == ST_SETUP && bus.PGRANT) begin
                        bus.PENABLE <= 1'b1;
                        state       <= ST_ACCESS;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                ST_ERR1: begin
                    bus.HREADYOUT <= 1'b1;
                    state         <= ST_ERR2;
                end
                ST_ERR2: begin
                    bus.HRESP <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_apb_bridge.sv
// tb_ahb_apb_bridge: schedule-based reference model for the AHB-to-APB bridge with directed and random transfers.
// Timeout scenarios run only when APB_TIMEOUT_EN is defined.
module tb_ahb_apb_bridge;
    localparam int TO = 16;
`ifdef APB_TIMEOUT_EN
    localparam int LIMIT = TO;
`else
    localparam int LIMIT = 1 << 30;
`endif

    logic PCLK = 1'b0;
    logic PRST;

    always #5 PCLK = ~PCLK;

    ahb_apb_bridge_if bus();

    ahb_apb_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .PCLK(PCLK),
        .PRST(PRST),
        .bus(bus)
    );

    int checks = 0, errors = 0, cyc = 0;
    int n_setup = 0, n_access = 0, n_psel = 0, n_resp = 0;
    logic [3:0]  cap_psel, cap_pstrb;
    logic [31:0] cap_pwdata;

    logic       e_hr, e_resp, e_pen, e_cp;
    logic [3:0] e_psel;

    logic [31:0] m_hrdata, m_paddr, m_pwdata;
    logic        m_pwrite;
    logic [3:0]  m_pstrb;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic set_exp(logic hr, logic resp, logic [3:0] psel, logic pen, logic cp);
        e_hr = hr; e_resp = resp; e_psel = psel; e_pen = pen; e_cp = cp;
    endtask

    // Check the current cycle at the falling edge, then advance to just after the next rising edge
    task automatic step();
        @(negedge PCLK);
        chk("HREADYOUT", bus.HREADYOUT, e_hr);
        chk("HRESP", bus.HRESP, e_resp);
        chk("PSEL", bus.PSEL, e_psel);
        chk("PENABLE", bus.PENABLE, e_pen);
        chk("HRDATA", bus.HRDATA, m_hrdata);
        if (e_cp) begin
            chk("PADDR", bus.PADDR, m_paddr);
            chk("PWRITE", bus.PWRITE, m_pwrite);
            chk("PSTRB", bus.PSTRB, m_pstrb);
            chk("PWDATA", bus.PWDATA, m_pwdata);
        end
        if (bus.PSEL != 0 && !bus.PENABLE) n_setup++;
        if (bus.PENABLE) n_access++;
        if (bus.HRESP) n_resp++;
        if (bus.PSEL != 0) begin
            n_psel++;
            cap_psel = bus.PSEL;
            cap_pstrb = bus.PSTRB;
            cap_pwdata = bus.PWDATA;
        end
        @(posedge PCLK);
        #1;
        cyc++;
    endtask

    // Strobes cover the bytes of the size-aligned container holding the address
    function automatic logic [3:0] model_strb(logic [2:0] size, logic [1:0] a);
        int n = 1 << size;
        int lo = int'(a) & ~(n - 1);
        logic [3:0] s = 4'b0000;
        for (int b = 0; b < 4; b++) if (b >= lo && b < lo + n) s[b] = 1'b1;
        return s;
    endfunction

    task automatic ahb_idle();
        bus.HSEL = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HREADY = 1'b1;
    endtask

    task automatic model_reset();
        m_hrdata = '0; m_paddr = '0; m_pwdata = '0; m_pwrite = 1'b0; m_pstrb = '0;
    endtask

    // Called in a cycle where the bridge can accept; returns in DONE (or IDLE after an error/reset)
    task automatic xfer(logic wr, logic [31:0] addr, logic [2:0] size, logic [31:0] wd, logic [31:0] rd,
                        int g, int r, int rst_at = -1);
        logic [3:0] sel = 4'b0001 << addr[31:30];
        int nb = 1 << size;
        logic err = size > 3'd2 || (int'(addr[1:0]) % nb) != 0;
        int n = 0;
        logic timed = 1'b0;
        bus.HSEL = 1'b1;
        bus.HTRANS = ($urandom % 2) ? 2'b11 : 2'b10;
        bus.HADDR = addr;
        bus.HWRITE = wr;
        bus.HSIZE = size;
        bus.HREADY = 1'b1;
        bus.HWDATA = $urandom;
        step();
        ahb_idle();
        if (err) begin
            set_exp(0, 1, 0, 0, 0);
            step();
            set_exp(1, 1, 0, 0, 0);
            step();
            set_exp(1, 0, 0, 0, 0);
            return;
        end
        m_paddr = addr;
        m_pwrite = wr;
        m_pstrb = wr ? model_strb(size, addr[1:0]) : 4'b0000;
        if (wr) begin
            bus.HWDATA = wd;
            set_exp(0, 0, 0, 0, 0);
            step();
            m_pwdata = wd;
            bus.HWDATA = $urandom;
        end
        for (int i = 0; i <= g; i++) begin
            if (n == LIMIT) begin
                timed = 1'b1;
                break;
            end
            bus.PGRANT = (i == g);
            bus.PREADY = 1'($urandom);
            bus.PRDATA = $urandom;
            set_exp(0, 0, sel, 0, 1);
            n++;
            step();
        end
        if (!timed) begin
            for (int j = 0; j <= r; j++) begin
                if (n == LIMIT) begin
                    timed = 1'b1;
                    break;
                end
                if (j == rst_at) begin
                    bus.PREADY = 1'b0;
                    PRST = 1'b1;
                    set_exp(0, 0, sel, 1, 1);
                    step();
                    PRST = 1'b0;
                    model_reset();
                    set_exp(1, 0, 0, 0, 1);
                    return;
                end
                bus.PREADY = (j == r);
                bus.PGRANT = 1'($urandom);
                bus.PRDATA = (j == r) ? rd : $urandom;
                set_exp(0, 0, sel, 1, 1);
                n++;
                step();
            end
        end
        bus.PREADY = 1'b0;
        bus.PGRANT = 1'b0;
        if (timed) begin
            set_exp(0, 1, 0, 0, 0);
            step();
            set_exp(1, 1, 0, 0, 0);
            step();
            set_exp(1, 0, 0, 0, 0);
            return;
        end
        if (!wr) m_hrdata = rd;
        set_exp(1, 0, 0, 0, 0);
    endtask

    // Idle cycles with bus traffic that must not be accepted
    task automatic idle(int n);
        for (int k = 0; k < n; k++) begin
            case ($urandom % 4)
                0: begin bus.HSEL = 1'b0; bus.HTRANS = 2'b10; bus.HREADY = 1'b1; end
                1: begin bus.HSEL = 1'b1; bus.HTRANS = 2'b00; bus.HREADY = 1'b1; end
                2: begin bus.HSEL = 1'b1; bus.HTRANS = 2'b01; bus.HREADY = 1'b1; end
                default: begin bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HREADY = 1'b0; end
            endcase
            bus.HADDR = $urandom;
            bus.HWRITE = 1'($urandom);
            bus.HSIZE = 3'($urandom);
            step();
            set_exp(1, 0, 0, 0, 0);
        end
        ahb_idle();
    endtask

    int c0, s0, a0, p0, r0;
    logic wr;
    logic [2:0] sz;

    initial begin
        PRST = 1'b1;
        ahb_idle();
        bus.HADDR = '0; bus.HWRITE = 1'b0; bus.HSIZE = '0; bus.HWDATA = '0;
        bus.PREADY = 1'b0; bus.PRDATA = '0; bus.PGRANT = 1'b0;
        model_reset();
        set_exp(1, 0, 0, 0, 1);
        @(posedge PCLK);
        #1;
        step();
        step();
        PRST = 1'b0;
        step();
        chk("rst_hreadyout", bus.HREADYOUT, 1);
        chk("rst_psel", bus.PSEL, 0);

        c0 = cyc; s0 = n_setup; a0 = n_access;
        xfer(0, 32'h8000_0010, 3'd2, 0, 32'hDEAD_BEEF, 0, 0);
        chk("rd_latency", cyc - c0, 3);
        chk("rd_setup_cycles", n_setup - s0, 1);
        chk("rd_access_cycles", n_access - a0, 1);
        chk("rd_psel", cap_psel, 4'b0100);
        chk("rd_pstrb", cap_pstrb, 4'b0000);
        chk("rd_hrdata", bus.HRDATA, 32'hDEAD_BEEF);
        chk("rd_done_hreadyout", bus.HREADYOUT, 1);
        idle(2);

        c0 = cyc;
        xfer(1, 32'h4000_0003, 3'd0, 32'h1122_3344, $urandom, 0, 0);
        chk("wr_latency", cyc - c0, 4);
        chk("wr_psel", cap_psel, 4'b0010);
        chk("wr_pstrb", cap_pstrb, 4'b1000);
        chk("wr_pwdata", cap_pwdata, 32'h1122_3344);

        c0 = cyc;
        xfer(0, 32'h0000_0004, 3'd2, 0, 32'h0BAD_F00D, 0, 0);
        chk("b2b_latency", cyc - c0, 3);
        chk("b2b_hrdata", bus.HRDATA, 32'h0BAD_F00D);

        s0 = n_setup; a0 = n_access;
        xfer(0, 32'hC000_0008, 3'd2, 0, 32'h1234_5678, 3, 2);
        chk("wait_setup_cycles", n_setup - s0, 4);
        chk("wait_access_cycles", n_access - a0, 3);
        chk("wait_psel", cap_psel, 4'b1000);
        idle(1);

        c0 = cyc; p0 = n_psel; r0 = n_resp;
        xfer(1, 32'h0000_0000, 3'd3, 32'hFFFF_FFFF, 0, 0, 0);
        chk("err_size_latency", cyc - c0, 3);
        chk("err_size_resp_cycles", n_resp - r0, 2);
        chk("err_size_psel_cycles", n_psel - p0, 0);
        p0 = n_psel; r0 = n_resp;
        xfer(0, 32'h0000_0001, 3'd1, 0, 0, 0, 0);
        chk("err_half_resp_cycles", n_resp - r0, 2);
        chk("err_half_psel_cycles", n_psel - p0, 0);
        chk("err_hrdata_held", bus.HRDATA, 32'h1234_5678);

        xfer(1, 32'h4000_0004, 3'd2, 32'hA5A5_A5A5, 0, 0, 3, 1);
        chk("midrst_psel", bus.PSEL, 0);
        chk("midrst_penable", bus.PENABLE, 0);
        chk("midrst_paddr", bus.PADDR, 0);
        chk("midrst_pwdata", bus.PWDATA, 0);
        chk("midrst_hrdata", bus.HRDATA, 0);
        idle(2);

`ifdef APB_TIMEOUT_EN
        s0 = n_setup; a0 = n_access; r0 = n_resp;
        xfer(0, 32'h8000_0000, 3'd2, 0, 32'h7777_7777, 2, 1000);
        chk("to_busy_cycles", (n_setup - s0) + (n_access - a0), TO);
        chk("to_resp_cycles", n_resp - r0, 2);
        chk("to_hrdata", bus.HRDATA, 0);
        idle(1);
`endif

        for (int t = 0; t < 150; t++) begin
            wr = 1'($urandom);
            sz = ($urandom % 8 == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom % 3);
            xfer(wr, $urandom, sz, $urandom, $urandom, $urandom % 4, $urandom % 4);
            idle($urandom % 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ahb_apb_bridge.md
# ahb_apb_bridge

Single-master AHB-Lite to APB bridge that converts one AHB-Lite slave transfer into one APB transaction on a master port of the 4-master/4-slave APB interconnect. It sits directly upstream of the interconnect: it drives PSEL/PADDR/PWRITE/PWDATA/PSTRB/PENABLE, waits for PGRANT and PREADY, and returns read data and status to the AHB side. Up to four instances feed the four interconnect master ports.

## Interface
- TIMEOUT_CYCLES, 16: APB wait limit in cycles, counted in SETUP+ACCESS; only used when APB_TIMEOUT_EN is defined.
- PCLK  in  1  clock; everything is sampled on the rising edge.
- PRST  in  1  reset, synchronous and active-high.
- HSEL  in  1  AHB slave select.
- HADDR  in  32  AHB address.
- HTRANS  in  2  transfer type; only NONSEQ (2'b10) and SEQ (2'b11) start a transfer.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 = byte, 1 = half, 2 = word; any other value is unsupported.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-wide ready.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  1 = ERROR.
- HRDATA  out  32  read data.
- PSEL  out  4  one-hot slave select, index = PADDR[31:30].
- PADDR  out  32  APB address.
- PWRITE  out  1  APB direction.
- PWDATA  out  32  APB write data.
- PSTRB  out  4  byte strobes.
- PENABLE  out  1  access-phase flag.
- PREADY  in  1  slave ready, returned by the interconnect.
- PRDATA  in  32  read data from the interconnect.
- PGRANT  in  1  interconnect arbitration grant.

## Operation
- Accept: a transfer is accepted when HSEL & HREADY & HTRANS[1] is high in state IDLE or DONE.
  - HADDR, HWRITE and HSIZE are registered on acceptance.
  - HTRANS IDLE or BUSY, or HSEL = 0, is ignored.
- States:
  - IDLE: HREADYOUT = 1.
  - WDATA: writes only; one cycle; HWDATA is latched into PWDATA; HREADYOUT = 0.
  - SETUP: PSEL[addr[31:30]] = 1, PENABLE = 0. Stays until PGRANT = 1, then goes to ACCESS.
  - ACCESS: PENABLE = 1. Stays until PREADY = 1.
    - Reads: PRDATA is registered into HRDATA.
    - Then go to DONE.
  - DONE: HREADYOUT = 1; PSEL and PENABLE are 0. A new accepted transfer goes to WDATA or SETUP; otherwise go to IDLE.
  - ERR1: HREADYOUT = 0, HRESP = 1.
  - ERR2: HREADYOUT = 1, HRESP = 1, then IDLE.
- Error checks at acceptance:
  - HSIZE > 2 → ERR1.
  - Half-word with HADDR[0] = 1 → ERR1.
  - Word with HADDR[1:0] ≠ 0 → ERR1.
  - In all three cases no APB activity is generated.
- PSTRB:
  - Byte: 4'b0001 << HADDR[1:0].
  - Half: 4'b0011 << (2·HADDR[1]).
  - Word: 4'b1111.
  - Reads: always 4'b0000.
- PADDR, PWRITE, PSTRB and PWDATA are held stable from SETUP through the last ACCESS cycle.
- HRDATA holds its value until the next read completes.
- Reset values: HREADYOUT = 1; HRESP = 0; HRDATA = 0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0; PSTRB = 0; state = IDLE.
- Reset asserted mid-transfer: at the next edge the bridge enters IDLE and all outputs take their reset values. The APB transfer is abandoned.
- PGRANT dropping during ACCESS is ignored; the bridge completes on PREADY.

## Timing
- Latency, with the address phase at T0:
  - Read: SETUP T1, ACCESS T2, DONE T3.
  - Write: WDATA T1, SETUP T2, ACCESS T3, DONE T4.
  - Each cycle PGRANT is low adds one SETUP cycle. Each cycle PREADY is low adds one ACCESS cycle.
- Back-to-back: a transfer accepted in DONE enters SETUP or WDATA on the next edge. There is no idle gap.
- Error response: always exactly 2 cycles (ERR1, ERR2).

## Configuration
- APB_TIMEOUT_EN defined:
  - A counter runs in SETUP+ACCESS and clears on entry to SETUP.
  - When the count reaches TIMEOUT_CYCLES, at the next edge PSEL and PENABLE drop to 0 and the state goes to ERR1.
  - HRDATA is unchanged.
- APB_TIMEOUT_EN undefined: no counter is built, and the bridge waits indefinitely for PGRANT and PREADY.

## Structure
- Package ahb_apb_pkg holds:
  - bridge state enum;
  - HTRANS and HSIZE constants;
  - strobe-generation function;
  - alignment-check function.
- Sub-module apb_timeout_counter: load, clear and expire outputs. It is instantiated only under APB_TIMEOUT_EN.

## Test plan
- Read word, HADDR 0x8000_0010: PGRANT = 1 and PREADY = 1 immediately; PRDATA = 0xDEAD_BEEF → PSEL = 4'b0100 at T1, PENABLE at T2, HRDATA = 0xDEAD_BEEF with HREADYOUT = 1 at T3, PSTRB = 0.
- Write byte, HADDR 0x4000_0003, HWDATA 0x1122_3344 → PSEL = 4'b0010, PSTRB = 4'b1000, PWDATA = 0x1122_3344, DONE at T4.
- PGRANT low for 3 cycles, then PREADY low for 2 cycles → SETUP lasts 4 cycles, ACCESS lasts 3 cycles, all P* outputs stable throughout.
- HSIZE = 3, or half-word at HADDR 0x1 → two-cycle ERROR response, PSEL never asserted.
- APB_TIMEOUT_EN with TIMEOUT_CYCLES = 16 and PREADY stuck low → PSEL drops and ERR1 is entered exactly at the expiry edge. Separately, PRST pulsed during ACCESS → all outputs return to reset values at the next edge.
